// File: rtl/poker_action_select.sv
// -----------------------------------------------------------------------------
// poker_action_select
//
// Turns one-cycle go/left/right key pulses into one betting decision per turn
// (fold, call/check, raise + amount) for the game controller.
//
// Ports
//   clock, resetn      : clock, synchronous active-low reset
//   go, left, right    : one-cycle key pulses (priority go > left > right)
//   turn_en            : controller asks this player for a decision
//   to_call            : chips needed to call, sampled when the turn starts
//   chips_avail        : player stack, sampled when the turn starts
//   action_ack         : controller accepts the presented action
//   busy               : high whenever the block is not idle
//   cursor             : 0=fold 1=call 2=raise (display)
//   in_raise           : high while the raise amount is being adjusted
//   raise_amt          : current raise total
//   action_valid       : decision available
//   action_code        : 0=fold 1=call 2=raise
//   action_amt         : chips committed by the decision
//   dbg_state          : current FSM state (0 idle, 1 select, 2 raise adjust,
//                        3 issue)
//
// Handshake: action_valid rises on the edge that accepts the confirming go and
// stays high, with action_code/action_amt frozen, until action_ack is sampled
// high at a clock edge; on that edge the transfer completes and valid, code
// and amount all return to 0. An ack in the first valid cycle completes the
// transfer.
// -----------------------------------------------------------------------------
module poker_action_select #(
  parameter int CHIP_W     = 10,
  parameter int RAISE_STEP = 10
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              go,
  input  logic              left,
  input  logic              right,
  input  logic              turn_en,
  input  logic [CHIP_W-1:0] to_call,
  input  logic [CHIP_W-1:0] chips_avail,
  input  logic              action_ack,
  output logic              busy,
  output logic [1:0]        cursor,
  output logic              in_raise,
  output logic [CHIP_W-1:0] raise_amt,
  output logic              action_valid,
  output logic [1:0]        action_code,
  output logic [CHIP_W-1:0] action_amt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SELECT    = 2'd1,
    ST_RAISE_ADJ = 2'd2,
    ST_ISSUE     = 2'd3
  } state_t;

  localparam logic [1:0] CUR_FOLD  = 2'd0;
  localparam logic [1:0] CUR_CALL  = 2'd1;
  localparam logic [1:0] CUR_RAISE = 2'd2;

  // Step widened by one bit so every sum below has a carry bit to spare.
  localparam logic [CHIP_W:0] STEP_X = (CHIP_W+1)'(RAISE_STEP);

  // Registers
  state_t            r_state;
  logic [CHIP_W-1:0] r_tc;
  logic [CHIP_W-1:0] r_ch;
  logic [1:0]        r_cursor;
  logic [CHIP_W-1:0] r_raise_amt;
  logic              r_valid;
  logic [1:0]        r_code;
  logic [CHIP_W-1:0] r_amt;
  logic              r_busy;
  logic              r_in_raise;

  // Next-state / next-value wires
  state_t            w_state_nxt;
  logic [CHIP_W-1:0] w_tc_nxt;
  logic [CHIP_W-1:0] w_ch_nxt;
  logic [1:0]        w_cursor_nxt;
  logic [CHIP_W-1:0] w_raise_nxt;
  logic              w_valid_nxt;
  logic [1:0]        w_code_nxt;
  logic [CHIP_W-1:0] w_amt_nxt;

  // Pulse priority: only one pulse is acted on per cycle.
  logic w_go, w_left, w_right;
  assign w_go    = go;
  assign w_left  = left & ~go;
  assign w_right = right & ~go & ~left;

  // Minimum raise computed straight from the inputs, used when a turn starts.
  logic [CHIP_W:0]   w_in_sum;
  logic [CHIP_W-1:0] w_in_min;
  assign w_in_sum = {1'b0, to_call} + STEP_X;
  assign w_in_min = (w_in_sum > {1'b0, chips_avail}) ? chips_avail : w_in_sum[CHIP_W-1:0];

  // Quantities derived from the latched call/stack values.
  logic              w_raise_ok;
  logic [CHIP_W:0]   w_tc_sum;
  logic [CHIP_W-1:0] w_raise_min;
  logic [CHIP_W-1:0] w_call_amt;
  assign w_raise_ok  = (r_ch > r_tc);
  assign w_tc_sum    = {1'b0, r_tc} + STEP_X;
  assign w_raise_min = (w_tc_sum > {1'b0, r_ch}) ? r_ch : w_tc_sum[CHIP_W-1:0];
  // A short stack calls all-in.
  assign w_call_amt  = (r_tc < r_ch) ? r_tc : r_ch;

  // Raise up: saturate at the whole stack.
  logic [CHIP_W:0]   w_up_sum;
  logic [CHIP_W-1:0] w_raise_up;
  assign w_up_sum   = {1'b0, r_raise_amt} + STEP_X;
  assign w_raise_up = (w_up_sum > {1'b0, r_ch}) ? r_ch : w_up_sum[CHIP_W-1:0];

  // Raise down: the subtraction only happens when it cannot cross the floor,
  // so it can never wrap below zero.
  logic [CHIP_W:0]   w_dn_floor;
  logic [CHIP_W-1:0] w_raise_dn;
  logic              w_at_min;
  assign w_dn_floor = {1'b0, w_raise_min} + STEP_X;
  assign w_raise_dn = ({1'b0, r_raise_amt} >= w_dn_floor)
                    ? (r_raise_amt - STEP_X[CHIP_W-1:0]) : w_raise_min;
  assign w_at_min   = (r_raise_amt == w_raise_min);

  // Cursor movement. Without a legal raise the cursor toggles fold/call only.
  logic [1:0] w_cur_left, w_cur_right;
  always_comb begin
    w_cur_left  = CUR_CALL;
    w_cur_right = CUR_CALL;
    case (r_cursor)
      CUR_FOLD: begin
        w_cur_left  = w_raise_ok ? CUR_RAISE : CUR_CALL;
        w_cur_right = CUR_CALL;
      end
      CUR_CALL: begin
        w_cur_left  = CUR_FOLD;
        w_cur_right = w_raise_ok ? CUR_RAISE : CUR_FOLD;
      end
      CUR_RAISE: begin
        w_cur_left  = CUR_CALL;
        w_cur_right = CUR_FOLD;
      end
      default: begin
        w_cur_left  = CUR_CALL;
        w_cur_right = CUR_CALL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. A dropped turn_en wins over any key pulse.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (turn_en) w_state_nxt = ST_SELECT;
      end
      ST_SELECT: begin
        if (!turn_en)  w_state_nxt = ST_IDLE;
        else if (w_go) w_state_nxt = (r_cursor == CUR_RAISE) ? ST_RAISE_ADJ : ST_ISSUE;
      end
      ST_RAISE_ADJ: begin
        if (!turn_en)                w_state_nxt = ST_IDLE;
        else if (w_go)               w_state_nxt = ST_ISSUE;
        else if (w_left && w_at_min) w_state_nxt = ST_SELECT;
      end
      ST_ISSUE: begin
        if (action_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    w_tc_nxt     = r_tc;
    w_ch_nxt     = r_ch;
    w_cursor_nxt = r_cursor;
    w_raise_nxt  = r_raise_amt;
    w_valid_nxt  = r_valid;
    w_code_nxt   = r_code;
    w_amt_nxt    = r_amt;
    case (r_state)
      ST_IDLE: begin
        if (turn_en) begin
          w_tc_nxt     = to_call;
          w_ch_nxt     = chips_avail;
          w_cursor_nxt = CUR_CALL;
          w_raise_nxt  = w_in_min;
        end
      end
      ST_SELECT: begin
        if (turn_en) begin
          if (w_go) begin
            if (r_cursor != CUR_RAISE) begin
              w_valid_nxt = 1'b1;
              if (r_cursor == CUR_CALL) begin
                w_code_nxt = CUR_CALL;
                w_amt_nxt  = w_call_amt;
              end else begin
                w_code_nxt = CUR_FOLD;
                w_amt_nxt  = '0;
              end
            end
          end else if (w_left) begin
            w_cursor_nxt = w_cur_left;
          end else if (w_right) begin
            w_cursor_nxt = w_cur_right;
          end
        end
      end
      ST_RAISE_ADJ: begin
        if (turn_en) begin
          if (w_go) begin
            w_valid_nxt = 1'b1;
            w_code_nxt  = CUR_RAISE;
            w_amt_nxt   = r_raise_amt;
          end else if (w_left) begin
            if (w_at_min) w_cursor_nxt = CUR_RAISE;
            else          w_raise_nxt  = w_raise_dn;
          end else if (w_right) begin
            w_raise_nxt = w_raise_up;
          end
        end
      end
      ST_ISSUE: begin
        if (action_ack) begin
          w_valid_nxt = 1'b0;
          w_code_nxt  = CUR_FOLD;
          w_amt_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_tc        <= '0;
      r_ch        <= '0;
      r_cursor    <= CUR_FOLD;
      r_raise_amt <= '0;
      r_valid     <= 1'b0;
      r_code      <= CUR_FOLD;
      r_amt       <= '0;
      r_busy      <= 1'b0;
      r_in_raise  <= 1'b0;
    end else begin
      r_tc        <= w_tc_nxt;
      r_ch        <= w_ch_nxt;
      r_cursor    <= w_cursor_nxt;
      r_raise_amt <= w_raise_nxt;
      r_valid     <= w_valid_nxt;
      r_code      <= w_code_nxt;
      r_amt       <= w_amt_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_in_raise  <= (w_state_nxt == ST_RAISE_ADJ);
    end
  end

  assign busy         = r_busy;
  assign cursor       = r_cursor;
  assign in_raise     = r_in_raise;
  assign raise_amt    = r_raise_amt;
  assign action_valid = r_valid;
  assign action_code  = r_code;
  assign action_amt   = r_amt;
  assign dbg_state    = r_state;

endmodule
